hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Producer-side counterpart to the EX-stage operand bypass network. Tracks every
//  in-flight register write (ALU, load, multi-cycle MUL/DIV) and tells ID when a
//  source operand is not yet reachable through the MM/WB bypass paths.
//  Raises a stall that holds PC and IF/ID and inserts a bubble into ID/EX.
//  Sits beside the ID stage; one instance per core.
// PARAMETERS
//  NREG       32  architectural GPR count; entry 0 is hard-wired not-busy
//  AW          5  register index width, clog2(NREG)
//  LOAD_WAIT   1  load-use bubbles; load data first bypassable from WB
//  CW          2  per-entry countdown width; must hold LOAD_WAIT
// PORTS
//  clk         in   1   core clock, rising edge
//  rst         in   1   asynchronous reset, active-high
//  id_valid    in   1   ID holds a live instruction
//  id_rs       in   AW  source register 1
//  id_rs_used  in   1   instruction reads rs
//  id_rt       in   AW  source register 2
//  id_rt_used  in   1   instruction reads rt
//  id_rd       in   AW  destination register
//  id_regwr    in   1   instruction writes id_rd
//  id_class    in   2   producer class: 0=ALU, 1=load, 2=MDU, 3=reserved (treated as ALU)
//  id_flush    in   1   ID instruction squashed this cycle (branch/exception from EX)
//  mdu_done    in   1   MDU result enters WB this cycle
//  mdu_rd      in   AW  destination of the completing MDU op
//  stall       out  1   hold PC and IF/ID; bubble into ID/EX (combinational)
//  rs_wait     out  1   rs hazard present (combinational, diagnostic)
//  rt_wait     out  1   rt hazard present (combinational, diagnostic)
//  mdu_busy    out  1   MDU op outstanding (registered)
//  busy_vec    out  NREG  per-register pending-write flag (registered)
// BEHAVIOUR
//  State per entry r: cnt[r] (CW bits) = bubbles still owed; lng[r] = MDU write pending.
//  Global: mdu_pend (1 outstanding MDU op max), mdu_dst (AW bits).
//  Reset: all cnt/lng cleared; mdu_pend=0; mdu_busy=0; busy_vec=0; stall=0.
//  Reset asserted mid-stall or mid-MDU clears everything; no pending write survives.
//  hit(s) = used(s) && s!=0 && (cnt[s]!=0 || lng[s]).
//  rs_wait = id_valid && hit(rs); rt_wait likewise.
//  waw = id_valid && id_regwr && id_rd!=0 && lng[id_rd]  (no out-of-order writeback).
//  struct = id_valid && id_class==2 && mdu_pend.
//  stall = rs_wait | rt_wait | waw | struct. id_flush forces stall=0.
//  issue = id_valid && !stall && !id_flush && id_regwr && id_rd!=0.
//  Per cycle, in order (later step wins):
//   1. Every nonzero cnt decrements by 1 unconditionally; pipeline ahead of ID advances during stall.
//   2. mdu_done: lng[mdu_rd]=0, mdu_pend=0.
//      mdu_done with !mdu_pend or mdu_rd!=mdu_dst is a protocol error; the bench asserts it never happens.
//   3. issue sets state by class:
//      ALU: cnt=0 (MM bypass covers it, no bubble).
//      load: cnt=LOAD_WAIT.
//      MDU: lng=1, mdu_pend=1, mdu_dst=id_rd.
//  Release is visible next cycle. A consumer in ID in the same cycle as mdu_done still stalls that cycle.
//  Issue and release to the same rd in one cycle: issue wins; the entry stays/becomes busy.
//  id_rd==0 is never allocated. A source of r0 never hits.
//  busy_vec[r] = (cnt[r]!=0)|lng[r], registered. mdu_busy = mdu_pend.
//  Latency: load followed by a dependent instruction costs exactly LOAD_WAIT stall cycles.
//  ALU followed by a dependent instruction costs 0 stall cycles.
// STRUCTURE
//  Shared pkg: producer-class encodings (PC_ALU/PC_LOAD/PC_MDU), AW, NREG.
//  One sub-module sb_entry (cnt + lng flop, decrement/set/clear logic), generated NREG-1 times.
//  Top level holds the hit muxes, stall equation and MDU tracker.
// TESTING
//  1. lw r8 then add r9,r8,r1 back-to-back -> stall=1 for 1 cycle, rs_wait=1; add issues next cycle.
//  2. add r8 then sub r9,r8,r8 -> stall never asserts; busy_vec stays 0.
//  3. div r4 (MDU); 6 cycles later or r5,r4,r0 -> stall high until the cycle after mdu_done with mdu_rd=4.
//  4. MDU pending on r4; second MDU op -> struct stall. ALU write to r4 -> waw stall. ALU write to r6 -> no stall.
//  5. lw r8 with id_flush=1 in its ID cycle -> no allocation; following add r9,r8 does not stall.
//  6. rst pulsed while lng[4]=1 and cnt[8]=1 -> busy_vec=0, mdu_busy=0, stall=0 immediately (async).
//     Sources r0 with id_rs_used=1 never stall.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and producer-class encodings for the operand hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int SB_NREG      = 32;
    localparam int SB_AW        = 5;
    localparam int SB_LOAD_WAIT = 1;
    localparam int SB_CW        = 2;

    typedef enum logic [1:0] {
        PC_ALU  = 2'd0,
        PC_LOAD = 2'd1,
        PC_MDU  = 2'd2,
        PC_RSVD = 2'd3
    } pclass_e;

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One scoreboard entry: bubble countdown plus long-latency (MDU) pending flag.
module sb_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int CW        = SB_CW,
    parameter int LOAD_WAIT = SB_LOAD_WAIT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue,
    input  logic [1:0]    cls,
    input  logic          mdu_release,
    output logic [CW-1:0] cnt,
    output logic          lng,
    output logic          busy
);

    logic [CW-1:0] cnt_nxt;
    logic          lng_nxt;

    // Issue is evaluated last so it overrides both decrement and release.
    always_comb begin
        cnt_nxt = (cnt != '0) ? cnt - CW'(1) : cnt;
        lng_nxt = lng;
        if (mdu_release)
            lng_nxt = 1'b0;
        if (issue) begin
            case (pclass_e'(cls))
                PC_LOAD: cnt_nxt = CW'(LOAD_WAIT);
                PC_MDU:  lng_nxt = 1'b1;
                default: cnt_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            lng <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            lng <= lng_nxt;
        end
    end

    assign busy = (cnt != '0) | lng;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks in-flight register writes and stalls
// consumers whose operands are not yet reachable through the bypass network.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG      = SB_NREG,
    parameter int AW        = SB_AW,
    parameter int LOAD_WAIT = SB_LOAD_WAIT,
    parameter int CW        = SB_CW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic            id_rs_used,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_rt_used,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_regwr,
    input  logic [1:0]      id_class,
    input  logic            id_flush,
    input  logic            mdu_done,
    input  logic [AW-1:0]   mdu_rd,
    output logic            stall,
    output logic            rs_wait,
    output logic            rt_wait,
    output logic            mdu_busy,
    output logic [NREG-1:0] busy_vec
);

    logic [CW-1:0] cnt [NREG];
    logic          lng [NREG];
    logic          mdu_pend;
    logic [AW-1:0] mdu_dst;
    logic          waw;
    logic          mdu_conflict;
    logic          issue;

    assign cnt[0]      = '0;
    assign lng[0]      = 1'b0;
    assign busy_vec[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        sb_entry #(
            .CW        (CW),
            .LOAD_WAIT (LOAD_WAIT)
        ) u_entry (
            .clk         (clk),
            .rst         (rst),
            .issue       (issue && (id_rd == AW'(r))),
            .cls         (id_class),
            .mdu_release (mdu_done && (mdu_rd == AW'(r))),
            .cnt         (cnt[r]),
            .lng         (lng[r]),
            .busy        (busy_vec[r])
        );
    end

    always_comb begin
        rs_wait      = id_valid && id_rs_used && (id_rs != '0) &&
                       ((cnt[id_rs] != '0) || lng[id_rs]);
        rt_wait      = id_valid && id_rt_used && (id_rt != '0) &&
                       ((cnt[id_rt] != '0) || lng[id_rt]);
        waw          = id_valid && id_regwr && (id_rd != '0) && lng[id_rd];
        mdu_conflict = id_valid && (pclass_e'(id_class) == PC_MDU) && mdu_pend;
        stall        = !id_flush && (rs_wait || rt_wait || waw || mdu_conflict);
        issue        = id_valid && !stall && !id_flush && id_regwr && (id_rd != '0);
    end

    // Only one MDU op may be outstanding; a new issue wins over a same-cycle completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdu_pend <= 1'b0;
            mdu_dst  <= '0;
        end else begin
            if (mdu_done)
                mdu_pend <= 1'b0;
            if (issue && (pclass_e'(id_class) == PC_MDU)) begin
                mdu_pend <= 1'b1;
                mdu_dst  <= id_rd;
            end
        end
    end

    assign mdu_busy = mdu_pend;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic        id_rs_used;
    logic [4:0]  id_rt;
    logic        id_rt_used;
    logic [4:0]  id_rd;
    logic        id_regwr;
    logic [1:0]  id_class;
    logic        id_flush;
    logic        mdu_done;
    logic [4:0]  mdu_rd;
    logic        stall;
    logic        rs_wait;
    logic        rt_wait;
    logic        mdu_busy;
    logic [31:0] busy_vec;

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;
    logic [4:0]  tb_mdu_dst = '0;

    localparam logic [1:0] ALU = 2'd0, LD = 2'd1, MDU = 2'd2;

    hazard_scoreboard #(
        .NREG      (32),
        .AW        (5),
        .LOAD_WAIT (1),
        .CW        (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rs_used (id_rs_used),
        .id_rt      (id_rt),
        .id_rt_used (id_rt_used),
        .id_rd      (id_rd),
        .id_regwr   (id_regwr),
        .id_class   (id_class),
        .id_flush   (id_flush),
        .mdu_done   (mdu_done),
        .mdu_rd     (mdu_rd),
        .stall      (stall),
        .rs_wait    (rs_wait),
        .rt_wait    (rt_wait),
        .mdu_busy   (mdu_busy),
        .busy_vec   (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic rsu,
                         input logic [4:0] rt, input logic rtu, input logic [4:0] rd,
                         input logic wr, input logic [1:0] cls, input logic fl);
        id_valid = v;  id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
        id_rd = rd;    id_regwr = wr; id_class = cls; id_flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, ALU, 1'b0);
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // MDU completion must always match an outstanding op to the tracked destination.
    always @(negedge clk) begin
        if (mdu_done) begin
            check("mdu_done_pending", {31'd0, mdu_busy}, 32'd1);
            check("mdu_done_dst", {27'd0, mdu_rd}, {27'd0, tb_mdu_dst});
        end
    end

    initial begin
        rst = 1'b1;
        mdu_done = 1'b0;
        mdu_rd = '0;
        idle();
        repeat (2) @(posedge clk);
        settle();
        check("reset_busy_vec", busy_vec, 32'd0);
        check("reset_mdu_busy", {31'd0, mdu_busy}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        tick();
        rst = 1'b0;

        // Load-use: lw r8 ; add r9,r8,r1
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, LD, 1'b0);
        settle(); check("lw_issue_stall", {31'd0, stall}, 32'd0);
        tick();
        drive(1'b1, 5'd8, 1'b1, 5'd1, 1'b1, 5'd9, 1'b1, ALU, 1'b0);
        settle();
        check("lu_stall", {31'd0, stall}, 32'd1);
        check("lu_rs_wait", {31'd0, rs_wait}, 32'd1);
        check("lu_rt_wait", {31'd0, rt_wait}, 32'd0);
        check("lu_busy_vec", busy_vec, 32'h0000_0100);
        tick();
        settle();
        check("lu_stall_released", {31'd0, stall}, 32'd0);
        check("lu_busy_cleared", busy_vec, 32'd0);
        tick(); idle();
        settle(); check("lu_add_no_alloc", busy_vec, 32'd0);

        // ALU-use: add r8 ; sub r9,r8,r8
        tick();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, ALU, 1'b0);
        settle(); check("alu_prod_stall", {31'd0, stall}, 32'd0);
        tick();
        drive(1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, ALU, 1'b0);
        settle();
        check("alu_use_stall", {31'd0, stall}, 32'd0);
        check("alu_busy_vec", busy_vec, 32'd0);
        tick(); idle();

        // MDU: div r4 ; or r5,r4,r0 waits for mdu_done
        drive(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, MDU, 1'b0);
        settle(); check("div_issue_stall", {31'd0, stall}, 32'd0);
        tick(); tb_mdu_dst = 5'd4;
        drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b1, 5'd5, 1'b1, ALU, 1'b0);
        settle();
        check("div_mdu_busy", {31'd0, mdu_busy}, 32'd1);
        check("div_busy_vec", busy_vec, 32'h0000_0010);
        for (int i = 0; i < 5; i++) begin
            check("div_dep_stall", {31'd0, stall}, 32'd1);
            tick(); settle();
        end
        mdu_done = 1'b1; mdu_rd = 5'd4;
        #1;
        check("div_done_same_cycle", {31'd0, stall}, 32'd1);
        tick(); mdu_done = 1'b0;
        settle();
        check("div_dep_released", {31'd0, stall}, 32'd0);
        check("div_mdu_idle", {31'd0, mdu_busy}, 32'd0);
        tick(); idle();

        // Structural and WAW against an outstanding MDU op on r4
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, MDU, 1'b0);
        tick(); tb_mdu_dst = 5'd4;
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, MDU, 1'b0);
        settle();
        check("struct_stall", {31'd0, stall}, 32'd1);
        check("struct_rs_wait", {31'd0, rs_wait}, 32'd0);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, ALU, 1'b0);
        #1; check("waw_stall", {31'd0, stall}, 32'd1);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, ALU, 1'b0);
        #1; check("alu_r6_no_stall", {31'd0, stall}, 32'd0);
        tick(); idle();
        mdu_done = 1'b1; mdu_rd = 5'd4;
        tick(); mdu_done = 1'b0;
        settle();
        check("struct_mdu_idle", {31'd0, mdu_busy}, 32'd0);
        check("struct_busy_clear", busy_vec, 32'd0);

        // Flushed load does not allocate
        tick();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, LD, 1'b1);
        settle(); check("flush_lw_stall", {31'd0, stall}, 32'd0);
        tick();
        drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, ALU, 1'b0);
        settle();
        check("flush_dep_stall", {31'd0, stall}, 32'd0);
        check("flush_busy_vec", busy_vec, 32'd0);
        tick();

        // Asynchronous reset with lng[4] and cnt[8] live
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, MDU, 1'b0);
        tick(); tb_mdu_dst = 5'd4;
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, LD, 1'b0);
        tick();
        drive(1'b1, 5'd8, 1'b1, 5'd4, 1'b1, 5'd9, 1'b1, ALU, 1'b1);
        settle();
        check("pre_rst_busy_vec", busy_vec, 32'h0000_0110);
        check("flush_forces_no_stall", {31'd0, stall}, 32'd0);
        check("flush_rs_wait_diag", {31'd0, rs_wait}, 32'd1);
        id_flush = 1'b0;
        #1; check("pre_rst_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_busy_vec", busy_vec, 32'd0);
        check("async_rst_mdu_busy", {31'd0, mdu_busy}, 32'd0);
        check("async_rst_stall", {31'd0, stall}, 32'd0);
        tick(); rst = 1'b0;

        // r0 never hits and is never allocated
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, LD, 1'b0);
        settle(); check("r0_src_stall", {31'd0, stall}, 32'd0);
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, ALU, 1'b0);
        settle();
        check("r0_no_alloc", busy_vec, 32'd0);
        check("r0_src_stall2", {31'd0, stall}, 32'd0);
        tick(); idle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
